// File: rtl/sgpio_pkg.sv
// Shared constants and helpers for the SGPIO frame controller.
package sgpio_pkg;
  localparam int DISCARD_FRAMES = 2;
  localparam int DEBOUNCE_MAX   = 15;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sgpio_bit_debounce.sv
// One filtered RX bit: counts consecutive differing samples, flips after DEBOUNCE of them.
module sgpio_bit_debounce import sgpio_pkg::*; #(
  parameter int DEBOUNCE = 3
)(
  input  logic iClk,
  input  logic iRst,
  input  logic iClr,
  input  logic iLoad,
  input  logic iSample,
  input  logic iBit,
  output logic oBit,
  output logic oUpd
);
  localparam int CW = clog2(DEBOUNCE_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      cnt  <= '0;
      oBit <= 1'b0;
      oUpd <= 1'b0;
    end else begin
      oUpd <= 1'b0;
      if (iLoad) begin
        oBit <= iBit;
        cnt  <= '0;
      end else if (iSample) begin
        if (iBit == oBit) cnt <= '0;
        else if (cnt == LAST) begin
          oBit <= iBit;
          cnt  <= '0;
          oUpd <= 1'b1;
        end else cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/sgpio_frame_ctrl.sv
// SGPIO frame controller: TX image arbitration/commit, RX frame sampling and
// per-bit debounce, and serial master reset gating.
module sgpio_frame_ctrl import sgpio_pkg::*; #(
  parameter int BYTE_REGS = 1,
  parameter int DEBOUNCE  = 3,
  parameter logic [BYTE_REGS*8-1:0] DEFAULT_TX = '0,
  parameter int AW = (clog2(BYTE_REGS) > 1) ? clog2(BYTE_REGS) : 1
)(
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iEnable,
  output logic                   oSgpioRst_n,
  input  logic                   iLoad_n,
  output logic [BYTE_REGS*8-1:0] oTxPData,
  input  logic [BYTE_REGS*8-1:0] iRxPData,
  input  logic                   iReqA,
  input  logic                   iReqB,
  input  logic [AW-1:0]          iAddrA,
  input  logic [AW-1:0]          iAddrB,
  input  logic [7:0]             iDataA,
  input  logic [7:0]             iDataB,
  output logic                   oAckA,
  output logic                   oAckB,
  output logic [BYTE_REGS*8-1:0] oRxData,
  output logic                   oRxValid,
  output logic                   oRxChg,
  output logic                   oFrameTick
);
  localparam int NB = BYTE_REGS * 8;

  logic [BYTE_REGS-1:0][7:0] shadow, shadowNext, active;
  logic          lastB, grantA, grantB;
  logic [AW-1:0] wrAddr;
  logic [7:0]    wrData;
  logic          loadLowQ, loadFall, sampleEn, rxLoad, rxSample;
  logic [1:0]    vldPipe;
  logic [1:0]    frameCnt;
  logic [NB-1:0] upd;

  // Out-of-range addresses match no byte lane, so they are acked and dropped.
  always_comb begin
    grantA     = ~iRst & iReqA & (~iReqB | lastB);
    grantB     = ~iRst & iReqB & ~grantA;
    wrAddr     = grantA ? iAddrA : iAddrB;
    wrData     = grantA ? iDataA : iDataB;
    shadowNext = shadow;
    for (int b = 0; b < BYTE_REGS; b++)
      if ((grantA | grantB) && int'(wrAddr) == b) shadowNext[b] = wrData;
  end

  assign oAckA      = grantA;
  assign oAckB      = grantB;
  assign oTxPData   = active;
  assign loadFall   = ~iLoad_n & ~loadLowQ;
  assign sampleEn   = vldPipe[0] & iEnable;
  assign rxLoad     = sampleEn & (frameCnt == 2'(DISCARD_FRAMES)) & ~oRxValid;
  assign rxSample   = sampleEn & oRxValid;
  assign oFrameTick = vldPipe[1];
  assign oRxChg     = |upd;

  // vldPipe[0]: load edge seen, sample next edge; vldPipe[1]: sample taken.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oSgpioRst_n <= 1'b0;
      shadow      <= DEFAULT_TX;
      active      <= DEFAULT_TX;
      lastB       <= 1'b1;
      loadLowQ    <= 1'b0;
      vldPipe     <= '0;
      frameCnt    <= '0;
      oRxValid    <= 1'b0;
    end else begin
      oSgpioRst_n <= iEnable;
      shadow      <= shadowNext;
      if (~iLoad_n && oSgpioRst_n) active <= shadowNext;
      if (grantA) lastB <= 1'b0;
      else if (grantB) lastB <= 1'b1;
      loadLowQ <= ~iLoad_n;
      vldPipe  <= {sampleEn, loadFall & iEnable};
      if (!iEnable) begin
        frameCnt <= '0;
        oRxValid <= 1'b0;
      end else if (sampleEn) begin
        if (frameCnt < 2'(DISCARD_FRAMES)) frameCnt <= frameCnt + 2'd1;
        else oRxValid <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_bit
    sgpio_bit_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .iClk    (iClk),
      .iRst    (iRst),
      .iClr    (~iEnable),
      .iLoad   (rxLoad),
      .iSample (rxSample),
      .iBit    (iRxPData[i]),
      .oBit    (oRxData[i]),
      .oUpd    (upd[i])
    );
  end
endmodule

// File: tb/tb_sgpio_frame_ctrl.sv
// Randomized scoreboard bench for sgpio_frame_ctrl with a frame-level reference model.
module tb_sgpio_frame_ctrl;
  localparam int BR  = 3;
  localparam int NB  = BR * 8;
  localparam int DEB = 3;
  localparam logic [NB-1:0] DEF = 24'h5AC3E1;

  logic iClk = 1'b0;
  logic iRst, iEnable, oSgpioRst_n, iLoad_n;
  logic [NB-1:0] oTxPData, iRxPData, oRxData;
  logic iReqA, iReqB, oAckA, oAckB, oRxValid, oRxChg, oFrameTick;
  logic [1:0] iAddrA, iAddrB;
  logic [7:0] iDataA, iDataB;

  always #5 iClk = ~iClk;

  sgpio_frame_ctrl #(.BYTE_REGS(BR), .DEBOUNCE(DEB), .DEFAULT_TX(DEF)) dut (
    .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .oSgpioRst_n(oSgpioRst_n),
    .iLoad_n(iLoad_n), .oTxPData(oTxPData), .iRxPData(iRxPData),
    .iReqA(iReqA), .iReqB(iReqB), .iAddrA(iAddrA), .iAddrB(iAddrB),
    .iDataA(iDataA), .iDataB(iDataB), .oAckA(oAckA), .oAckB(oAckB),
    .oRxData(oRxData), .oRxValid(oRxValid), .oRxChg(oRxChg), .oFrameTick(oFrameTick)
  );

  int tests = 0, fails = 0;

  typedef struct {
    bit          rstN;
    logic [NB-1:0] tx;
    bit          valid;
    logic [NB-1:0] rx;
  } st_t;

  st_t stQ[$];
  bit  ackQ[$];   // 0 = A expected, 1 = B expected
  bit  tickQ[$];  // expected oRxChg with each frame tick
  st_t me;
  bit  mb;

  // reference model state
  logic [7:0]    mShadow [BR];
  logic [7:0]    mActive [BR];
  bit            mRstN, mLastB, mLoadLowPrev, mPend, mValid;
  int            mFrames;
  logic [NB-1:0] mRx;
  int            mCnt [NB];

  // requester / framer state
  bit         pendA, pendB, run;
  logic [1:0] addrA, addrB;
  logic [7:0] dataA, dataB;
  int         gap, lowLeft, dirIdx;
  logic       loadN;
  logic [NB-1:0] rxv, stable;
  logic [NB-1:0] dirTab [9] = '{24'h0, 24'h0, 24'h0, 24'h1, 24'h1, 24'h0, 24'h1, 24'h1, 24'h1};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] img();
    logic [NB-1:0] v;
    for (int b = 0; b < BR; b++) v[b*8 +: 8] = mActive[b];
    return v;
  endfunction

  task automatic clear_rx();
    mFrames = 0;
    mValid  = 0;
    mRx     = '0;
    for (int i = 0; i < NB; i++) mCnt[i] = 0;
  endtask

  // One clock of the spec's behaviour, evaluated with this cycle's inputs.
  task automatic model_step();
    bit gA, gB, chg;
    if (iRst) begin
      mRstN = 0; mLastB = 1; mLoadLowPrev = 0; mPend = 0;
      for (int b = 0; b < BR; b++) begin
        mShadow[b] = DEF[b*8 +: 8];
        mActive[b] = DEF[b*8 +: 8];
      end
      clear_rx();
      return;
    end
    gA = pendA && (!pendB || mLastB);
    gB = pendB && !gA;
    if (gA) begin
      ackQ.push_back(1'b0);
      if (int'(addrA) < BR) mShadow[addrA] = dataA;
      mLastB = 0; pendA = 0;
    end
    if (gB) begin
      ackQ.push_back(1'b1);
      if (int'(addrB) < BR) mShadow[addrB] = dataB;
      mLastB = 1; pendB = 0;
    end
    if (!iLoad_n && mRstN) mActive = mShadow;
    if (mPend && iEnable) begin
      chg = 0;
      if (mFrames < 2) mFrames++;
      else if (!mValid) begin
        mRx = iRxPData; mValid = 1;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (iRxPData[i] != mRx[i]) begin
            mCnt[i]++;
            if (mCnt[i] == DEB) begin
              mRx[i] = iRxPData[i]; mCnt[i] = 0; chg = 1;
            end
          end else mCnt[i] = 0;
        end
      end
      tickQ.push_back(chg);
    end
    mPend = iEnable && !iLoad_n && !mLoadLowPrev;
    mLoadLowPrev = !iLoad_n;
    if (!iEnable) clear_rx();
    mRstN = iEnable;
  endtask

  always @(negedge iClk) begin
    if (stQ.size() > 0) begin
      me = stQ.pop_front();
      chk("sgpio_rst_n", 32'(oSgpioRst_n), 32'(me.rstN));
      chk("tx_pdata",    32'(oTxPData),    32'(me.tx));
      chk("rx_valid",    32'(oRxValid),    32'(me.valid));
      chk("rx_data",     32'(oRxData),     32'(me.rx));
    end
    if (oAckA || oAckB) begin
      if (ackQ.size() == 0) chk("ack_spurious", 32'({oAckA, oAckB}), 32'd0);
      else begin
        mb = ackQ.pop_front();
        chk("ack_side", 32'({oAckA, oAckB}), mb ? 32'd1 : 32'd2);
      end
    end
    if (oFrameTick) begin
      if (tickQ.size() == 0) chk("tick_spurious", 32'(oFrameTick), 32'd0);
      else chk("rx_chg", 32'(oRxChg), 32'(tickQ.pop_front()));
    end else if (oRxChg) chk("chg_without_tick", 32'(oRxChg), 32'd0);
  end

  initial begin
    iRst = 1; iEnable = 0; iLoad_n = 1; iRxPData = '0;
    iReqA = 0; iReqB = 0; iAddrA = 0; iAddrB = 0; iDataA = 0; iDataB = 0;
    pendA = 0; pendB = 0; run = 0; loadN = 1; rxv = '0; stable = 24'h1;
    gap = 0; lowLeft = 0; dirIdx = 0;
    addrA = 0; addrB = 0; dataA = 0; dataB = 0;
    for (int c = 0; c < 1400; c++) begin
      iRst    = (c < 3) || (c == 700) || (c == 701);
      iEnable = !((c < 3) || (c >= 400 && c < 407) || (c >= 1000 && c < 1003));
      if (c == 3) begin
        run = 1; gap = 2; lowLeft = 0; dirIdx = 0;
        pendA = 1; addrA = 2'd0; dataA = 8'hA5;
        pendB = 1; addrB = 2'd1; dataB = 8'h3C;
      end
      if (c == 1380) run = 0;
      loadN = 1'b1;
      if (run) begin
        if (!pendA && $urandom_range(0, 2) == 0) begin
          pendA = 1; addrA = 2'($urandom_range(0, 3)); dataA = 8'($urandom);
        end
        if (!pendB && $urandom_range(0, 2) == 0) begin
          pendB = 1; addrB = 2'($urandom_range(0, 3)); dataB = 8'($urandom);
        end
        if (lowLeft > 0) begin
          loadN = 1'b0; lowLeft--;
        end else if (gap == 0) begin
          loadN   = 1'b0;
          lowLeft = ($urandom_range(0, 7) == 0) ? 1 : 0;
          gap     = $urandom_range(3, 7);
          if (dirIdx < 9) begin
            rxv = dirTab[dirIdx]; dirIdx++;
          end else begin
            if ($urandom_range(0, 3) == 0) stable[$urandom_range(0, NB-1)] ^= 1'b1;
            rxv = stable;
            if ($urandom_range(0, 2) == 0) rxv[$urandom_range(0, NB-1)] ^= 1'b1;
          end
        end else gap--;
      end
      iReqA = pendA; iAddrA = addrA; iDataA = dataA;
      iReqB = pendB; iAddrB = addrB; iDataB = dataB;
      iLoad_n = loadN; iRxPData = rxv;
      model_step();
      @(posedge iClk); #1;
      stQ.push_back('{mRstN, img(), mValid, mRx});
    end
    iReqA = 0; iReqB = 0; iLoad_n = 1;
    repeat (4) @(posedge iClk);
    #1;
    chk("ack_queue_drained",   32'(ackQ.size()),  32'd0);
    chk("tick_queue_drained",  32'(tickQ.size()), 32'd0);
    chk("state_queue_drained", 32'(stQ.size()),   32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sgpio_frame_ctrl.md
# sgpio_frame_ctrl

Frame-level controller for the serial GPIO master. It owns the transmit register image and arbitrates byte writes from two internal requesters into that image. It commits the image atomically at each frame load, debounces the received parallel frame per bit, and gates the serial master's reset from an enable. It connects directly to the master's load, parallel-in and parallel-out ports on the same SGPIO clock.

## Interface
- BYTE_REGS, 1: byte registers per frame; must match the serial master.
- DEBOUNCE, 3: consecutive identical frames required to change a filtered RX bit; range 1..15.
- DEFAULT_TX, 0: reset value of the TX shadow and active images (BYTE_REGS*8 bits).
- AW, derived: max(1, clog2(BYTE_REGS)).
- iClk  in  1  SGPIO clock; all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iEnable  in  1  1 = run the serial master, 0 = hold it in reset.
- oSgpioRst_n  out  1  active-low reset to the serial master.
- iLoad_n  in  1  load strobe from the serial master.
- oTxPData  out  BYTE_REGS*8  active TX image to the master parallel input.
- iRxPData  in  BYTE_REGS*8  received parallel frame from the master.
- iReqA / iReqB  in  1  write request, held until acked.
- iAddrA / iAddrB  in  AW  byte index.
- iDataA / iDataB  in  8  write data.
- oAckA / oAckB  out  1  one-cycle grant pulse; write accepted that cycle.
- oRxData  out  BYTE_REGS*8  debounced RX image.
- oRxValid  out  1  oRxData is meaningful.
- oRxChg  out  1  one-cycle pulse: some oRxData bit changed.
- oFrameTick  out  1  one-cycle pulse per accepted RX frame sample.

## Operation
- Reset: oSgpioRst_n=0, shadow=active=oTxPData=DEFAULT_TX, oRxData=0, oRxValid=0, oRxChg=0, oFrameTick=0, oAckA=oAckB=0, arbiter last-grant=B (A wins first), frame count=0, debounce counters=0.
- Enable: oSgpioRst_n is the registered value of iEnable (one cycle of latency).
- While iEnable=0: frame count, debounce counters and oRxValid clear. oRxData clears to 0. TX shadow and active images and write arbitration are retained.
- Arbitration: two-way round-robin. If exactly one request is active, it is granted. If both are active, the side not granted last time wins. A grant pulses that side's ack for one cycle and writes shadow[addr*8 +: 8]. An out-of-range addr (>= BYTE_REGS) is acked and discarded. At most one write is accepted per cycle. A requester that is still requesting the cycle after its ack is treated as a new write.
- Commit: on each rising edge where iLoad_n=0 and oSgpioRst_n=1, active <= shadow. If a write is accepted in that same cycle, active receives the post-write shadow (forwarding). oTxPData changes only at commit.
- RX sampling: sample iRxPData on the rising edge one cycle after iLoad_n was seen low (the frame sample point) and pulse oFrameTick with that sample. The first two samples after enable are discarded, because they contain partial frames. The third sample loads oRxData directly and sets oRxValid=1, with no oRxChg.
- Debounce: after oRxValid=1, each bit keeps a counter. If the sample bit differs from the oRxData bit, the counter increments; once it reaches DEBOUNCE, the oRxData bit takes the sample value and the counter clears. If the sample bit equals the oRxData bit, the counter clears. oRxChg pulses in the cycle any bit updates. With DEBOUNCE=1, a bit updates on its first differing sample.

## Timing
- Write to oTxPData: visible at the next commit edge. The master captures it on the falling edge following that edge.
- iLoad_n low to oFrameTick/oRxData update: 1 cycle. oRxChg is coincident with the oRxData update.
- iLoad_n low held for more than 1 cycle (not expected): commit repeats each cycle, and only one sample is taken per low run (edge-detected).
- Reset overrides everything in its cycle, including a pending write or commit.
- Enable dropping mid-frame: the in-progress sample is discarded, and the next enable restarts the two-frame discard.

## Structure
- Shared package `sgpio_pkg`: constants for discard frame count (2) and the maximum DEBOUNCE (15), plus a `clog2` function.
- Sub-module `sgpio_bit_debounce`: a per-bit counter plus filtered bit, instantiated BYTE_REGS*8 times through a generate loop, with an update-pulse output. These update pulses are OR-reduced to form oRxChg.

## Test plan
- Reset/enable: assert iRst, then set iEnable=1 → oSgpioRst_n=1 one cycle later. oTxPData=DEFAULT_TX and oRxValid=0 until the third iLoad_n pulse, after which it is 1.
- Arbitration, BYTE_REGS=2: hold iReqA(addr0, 0xA5) and iReqB(addr1, 0x3C) together → ackA first, then ackB on the next cycle. oTxPData=0x3CA5 only after the next iLoad_n low edge.
- Write/commit collision: ackA coincides with the iLoad_n-low edge carrying 0x5A to addr0 → oTxPData[7:0]=0x5A at that edge.
- Debounce, DEBOUNCE=3: valid oRxData=0x00, then RX frames 0x01, 0x01, 0x00, 0x01, 0x01, 0x01 → oRxData[0] rises only on the sixth sample, with a single oRxChg pulse.
- Out-of-range write: BYTE_REGS=1, iAddrB=1 → ackB pulses and oTxPData is unchanged.
- Disable mid-run: with oRxValid=1, drop iEnable → oRxValid=0 and oRxData=0, oTxPData retained. Re-enable → two frame samples are discarded before oRxValid returns.
